// File: rtl/system_sysid_checker.sv
// ---------------------------------------------------------------------------
// system_sysid_checker
//   Boot-time sequencer that reads the system ID slave over Avalon-MM (word 0 =
//   system ID, word 1 = build timestamp) and validates both words against the
//   expected values. A mismatching pass is retried up to MAX_RETRIES more times
//   after a RETRY_GAP idle gap. A read stalled for TIMEOUT_CYCLES aborts the run.
//   The result gates firmware start.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   start                   1-cycle run request, honoured only in IDLE or DONE
//   avm_address/avm_read    Avalon read master (address 0 = ID, 1 = timestamp)
//   avm_readdata            read data, taken when avm_read=1 and waitrequest=0
//   avm_waitrequest         slave stall
//   busy                    high in RD_ID, RD_TS, CHECK, RETRY_WAIT
//   done / pass             run finished / both words matched
//   id_mismatch/ts_mismatch last completed pass compare results
//   timeout                 a read stalled too long
//   attempts                passes performed in this run
//   captured_id/ts          words read in the last pass
//   dbg_state_o             current FSM state, for debug and checkers
//
// Handshake: a read is issued by holding avm_read=1 with a stable avm_address;
// it completes in the first cycle where avm_waitrequest=0, and readdata is
// captured in that same cycle. Exactly one transfer happens per read state.
// ---------------------------------------------------------------------------
module system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'h00000000,
    parameter logic [31:0] EXPECTED_TS    = 32'h532C910A,
    parameter int          MAX_RETRIES    = 2,
    parameter int          RETRY_GAP      = 8,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [3:0]  attempts,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [2:0]  dbg_state_o
);

    // Counters only need to reach LIMIT-1 before the terminal decision.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W  = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_ID      = 3'd1,
        S_RD_TS      = 3'd2,
        S_CHECK      = 3'd3,
        S_RETRY_WAIT = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                pass_q, pass_d;
    logic                id_mis_q, id_mis_d;
    logic                ts_mis_q, ts_mis_d;
    logic                timeout_q, timeout_d;
    logic [3:0]          attempts_q, attempts_d;
    logic [31:0]         cap_id_q, cap_id_d;
    logic [31:0]         cap_ts_q, cap_ts_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            gap_cnt_q  <= '0;
            pass_q     <= 1'b0;
            id_mis_q   <= 1'b0;
            ts_mis_q   <= 1'b0;
            timeout_q  <= 1'b0;
            attempts_q <= 4'd0;
            cap_id_q   <= 32'd0;
            cap_ts_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pass_q     <= pass_d;
            id_mis_q   <= id_mis_d;
            ts_mis_q   <= ts_mis_d;
            timeout_q  <= timeout_d;
            attempts_q <= attempts_d;
            cap_id_q   <= cap_id_d;
            cap_ts_q   <= cap_ts_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        pass_d     = pass_q;
        id_mis_d   = id_mis_q;
        ts_mis_d   = ts_mis_q;
        timeout_d  = timeout_q;
        attempts_d = attempts_q;
        cap_id_d   = cap_id_q;
        cap_ts_d   = cap_ts_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A fresh run clears the previous verdict; captures are kept
                // until overwritten by the new reads.
                if (start) begin
                    state_d    = S_RD_ID;
                    wait_cnt_d = '0;
                    pass_d     = 1'b0;
                    id_mis_d   = 1'b0;
                    ts_mis_d   = 1'b0;
                    timeout_d  = 1'b0;
                    attempts_d = 4'd1;
                end
            end

            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest) begin
                    wait_cnt_d = '0;
                    if (state_q == S_RD_ID) begin
                        cap_id_d = avm_readdata;
                        state_d  = S_RD_TS;
                    end else begin
                        cap_ts_d = avm_readdata;
                        state_d  = S_CHECK;
                    end
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th stalled cycle: abandon the
                    // read without retrying.
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end

            S_CHECK: begin
                id_mis_d = (cap_id_q != EXPECTED_ID);
                ts_mis_d = (cap_ts_q != EXPECTED_TS);
                if ((cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TS)) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (attempts_q <= 4'(MAX_RETRIES)) begin
                    gap_cnt_d = '0;
                    state_d   = S_RETRY_WAIT;
                end else begin
                    pass_d  = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_RETRY_WAIT: begin
                if (gap_cnt_q == GAP_W'(RETRY_GAP - 1)) begin
                    attempts_d = (attempts_q == 4'd15) ? 4'd15 : attempts_q + 4'd1;
                    wait_cnt_d = '0;
                    state_d    = S_RD_ID;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes are decoded from the state register so a reset or timeout
    // drops avm_read at the very edge that leaves the read state.
    assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign avm_address = (state_q == S_RD_TS);
    assign busy        = (state_q == S_RD_ID) || (state_q == S_RD_TS) ||
                         (state_q == S_CHECK) || (state_q == S_RETRY_WAIT);
    assign done        = (state_q == S_DONE);
    assign pass        = pass_q;
    assign id_mismatch = id_mis_q;
    assign ts_mismatch = ts_mis_q;
    assign timeout     = timeout_q;
    assign attempts    = attempts_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_system_sysid_checker.sv
module tb_system_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'h00000000;
    localparam logic [31:0] BAD_ID  = 32'hDEADBEEF;
    localparam logic [31:0] GOOD_TS = 32'h532C910A;
    localparam logic [31:0] BAD_TS  = 32'h12345678;
    localparam int MAXR = 2;
    localparam int GAP  = 8;
    localparam int TMO  = 64;
    localparam int BOUND = 3000;

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;
    logic start;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- DUT ----------------
    logic        avm_address, avm_read, avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [3:0]  attempts;
    logic [31:0] captured_id, captured_ts;
    logic [2:0]  dbg_state;

    system_sysid_checker #(
        .EXPECTED_ID(GOOD_ID), .EXPECTED_TS(GOOD_TS),
        .MAX_RETRIES(MAXR), .RETRY_GAP(GAP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .pass(pass),
        .id_mismatch(id_mismatch), .ts_mismatch(ts_mismatch), .timeout(timeout),
        .attempts(attempts), .captured_id(captured_id), .captured_ts(captured_ts),
        .dbg_state_o(dbg_state)
    );

    // ---------------- slave model ----------------
    bit id_good;
    bit stuck;
    int bad_ts;     // number of leading timestamp reads that return BAD_TS
    int stall_len;  // waitrequest cycles before each read is accepted
    int ts_base;
    int stall_cnt = 0;
    int ts_reads = 0;

    assign avm_waitrequest = stuck || (avm_read && (stall_cnt < stall_len));
    assign avm_readdata = avm_address ? (((ts_reads - ts_base) < bad_ts) ? BAD_TS : GOOD_TS)
                                      : (id_good ? GOOD_ID : BAD_ID);

    always @(posedge clock) begin
        if (avm_read && !avm_waitrequest && !reset) begin
            stall_cnt <= 0;
            if (avm_address) ts_reads <= ts_reads + 1;
        end else if (avm_read && !reset) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
        end
    end

    // ---------------- bus monitor ----------------
    int  xfers = 0;
    int  proto_err = 0;
    bit  prev_stall = 1'b0;
    logic prev_addr = 1'b0;

    always @(negedge clock) begin
        if (avm_read && !avm_waitrequest && !reset) xfers++;
        if (avm_read && !busy) proto_err++;
        if (prev_stall && busy && !(avm_read && (avm_address == prev_addr))) proto_err++;
        prev_stall = avm_read && avm_waitrequest && !reset;
        prev_addr  = avm_address;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: passes repeat until both words match or the retry budget is
    // spent; each pass is two reads of (stall+1) cycles plus one compare cycle.
    task automatic model(input bit idg, input int bts, input int s,
                         output bit e_pass, output int e_att, output bit e_idm,
                         output bit e_tsm, output int e_lat);
        int k;
        bit ok;
        k = 0;
        ok = 1'b0;
        while (!ok && k < MAXR + 1) begin
            k++;
            ok = idg && (k > bts);
        end
        e_pass = ok;
        e_att  = k;
        e_idm  = !idg;
        e_tsm  = (k <= bts);
        e_lat  = k * (2 * (s + 1) + 1) + (k - 1) * GAP + 1;
    endtask

    // ---------------- driver ----------------
    // Pulses start, waits for done; lat is the cycle count from the start
    // edge to the first cycle with done=1. If poke>0 a second start pulse is
    // sampled at edge start+poke, and attempts one cycle later is returned.
    task automatic run(input bit idg, input int bts, input int s, input int poke,
                       output int lat, output logic [3:0] att_poke,
                       output int nx, output int nperr);
        int x0, p0;
        id_good   = idg;
        bad_ts    = bts;
        stall_len = s;
        ts_base   = ts_reads;
        x0 = xfers;
        p0 = proto_err;
        att_poke = 4'hx;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < BOUND) begin
            start = (lat == poke);
            @(negedge clock);
            lat++;
            if (lat == poke + 1) att_poke = attempts;
        end
        start = 1'b0;
        if (!done) check("done_wait_expired", 32'(done), 32'd1);
        nx = xfers - x0;
        nperr = proto_err - p0;
    endtask

    typedef struct {
        bit id_good;
        int bad_ts;
        int stall;
        bit exp_pass;
        int exp_att;
        bit exp_idm;
        bit exp_tsm;
        int exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, nx, nperr, cnt;
        logic [3:0] ap;
        bit e_pass, e_idm, e_tsm;
        int e_att, e_lat;

        vecs[0] = '{1'b1, 0,  0, 1'b1, 1, 1'b0, 1'b0, 4};
        vecs[1] = '{1'b1, 99, 0, 1'b0, 3, 1'b0, 1'b1, 26};
        vecs[2] = '{1'b1, 1,  0, 1'b1, 2, 1'b0, 1'b0, 15};
        vecs[3] = '{1'b1, 0,  3, 1'b1, 1, 1'b0, 1'b0, 10};
        vecs[4] = '{1'b0, 0,  0, 1'b0, 3, 1'b1, 1'b0, 26};
        vecs[5] = '{1'b1, 1,  2, 1'b1, 2, 1'b0, 1'b0, 23};

        reset = 1'b1; start = 1'b0; stuck = 1'b0;
        id_good = 1'b1; bad_ts = 0; stall_len = 0; ts_base = 0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_attempts", 32'(attempts), 32'd0);
        check("rst_cap_ts", captured_ts, 32'd0);

        // directed table
        for (int i = 0; i < 6; i++) begin
            run(vecs[i].id_good, vecs[i].bad_ts, vecs[i].stall, 0, lat, ap, nx, nperr);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_pass", i), 32'(pass), 32'(vecs[i].exp_pass));
            check($sformatf("vec%0d_attempts", i), 32'(attempts), 32'(vecs[i].exp_att));
            check($sformatf("vec%0d_id_mis", i), 32'(id_mismatch), 32'(vecs[i].exp_idm));
            check($sformatf("vec%0d_ts_mis", i), 32'(ts_mismatch), 32'(vecs[i].exp_tsm));
            check($sformatf("vec%0d_xfers", i), 32'(nx), 32'(2 * vecs[i].exp_att));
            check($sformatf("vec%0d_bus", i), 32'(nperr), 32'd0);
            if (vecs[i].exp_tsm == 1'b0)
                check($sformatf("vec%0d_cap_ts", i), captured_ts, GOOD_TS);
        end

        // randomized runs against the reference
        for (int i = 0; i < 25; i++) begin
            bit idg;
            int bts, s;
            idg = ($urandom_range(0, 3) != 0);
            bts = int'($urandom_range(0, 4));
            s   = int'($urandom_range(0, 4));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            model(idg, bts, s, e_pass, e_att, e_idm, e_tsm, e_lat);
            run(idg, bts, s, 0, lat, ap, nx, nperr);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(e_lat));
            check($sformatf("rnd%0d_pass", i), 32'(pass), 32'(e_pass));
            check($sformatf("rnd%0d_attempts", i), 32'(attempts), 32'(e_att));
            check($sformatf("rnd%0d_id_mis", i), 32'(id_mismatch), 32'(e_idm));
            check($sformatf("rnd%0d_ts_mis", i), 32'(ts_mismatch), 32'(e_tsm));
            check($sformatf("rnd%0d_cap_id", i), captured_id, idg ? GOOD_ID : BAD_ID);
            check($sformatf("rnd%0d_cap_ts", i), captured_ts, e_tsm ? BAD_TS : GOOD_TS);
            check($sformatf("rnd%0d_xfers", i), 32'(nx), 32'(2 * e_att));
            check($sformatf("rnd%0d_bus", i), 32'(nperr), 32'd0);
        end

        // stuck waitrequest: abort after TMO stalled cycles, no retry
        stuck = 1'b1;
        run(1'b1, 0, 0, 0, lat, ap, nx, nperr);
        check("tmo_latency", 32'(lat), 32'(TMO + 1));
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_pass", 32'(pass), 32'd0);
        check("tmo_read_dropped", 32'(avm_read), 32'd0);
        check("tmo_attempts", 32'(attempts), 32'd1);
        check("tmo_xfers", 32'(nx), 32'd0);
        stuck = 1'b0;

        // restart from DONE clears timeout on entry to the first read
        stall_len = 0;
        ts_base = ts_reads;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("restart_timeout_clr", 32'(timeout), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_attempts", 32'(attempts), 32'd1);
        cnt = 0;
        while (!done && cnt < BOUND) begin
            @(negedge clock);
            cnt++;
        end
        check("restart_pass", 32'(pass), 32'd1);

        // start pulse inside RETRY_WAIT is ignored
        run(1'b1, 99, 0, 5, lat, ap, nx, nperr);
        check("poke_attempts_mid", 32'(ap), 32'd1);
        check("poke_latency", 32'(lat), 32'd26);
        check("poke_attempts_end", 32'(attempts), 32'd3);

        // reset while reading the timestamp
        id_good = 1'b1; bad_ts = 0; stall_len = 2; ts_base = ts_reads;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cnt = 0;
        while (!(avm_read && avm_address) && cnt < 50) begin
            @(negedge clock);
            cnt++;
        end
        check("rdts_reached", 32'(avm_read && avm_address), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'd0);
        check("midrst_read", 32'(avm_read), 32'd0);
        check("midrst_addr", 32'(avm_address), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_attempts", 32'(attempts), 32'd0);
        check("midrst_cap_ts", captured_ts, 32'd0);
        cnt = 0;
        repeat (5) begin
            @(negedge clock);
            if (avm_read) cnt++;
        end
        check("midrst_no_bus", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
